li_fifo_drain: RTL and testbench
================================

Name: li_fifo_drain

Overview:
- Downstream consumer of the shell's single-clock FIFO wrapper (non-showahead, fixed read latency).
- Converts the FIFO's empty/deq interface into a valid/ready stream for the next pipeline stage (FIR core input or next shell hop).
- Issues reads speculatively, tracks in-flight reads, and lands returned words in a small register buffer. Full throughput (1 word/cycle) is sustained when downstream is always ready.

Parameters:
- DATA_WIDTH, 32, width of data words (signed, passed through unmodified).
- RD_LATENCY, 2, cycles from o_fifo_deq high to valid i_fifo_data (2 = BRAM with output register); legal 1..4.
- BUF_DEPTH, 4, output register-buffer entries; must be >= RD_LATENCY+1 for full throughput; power of 2.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_fifo_empty  in  1  FIFO empty flag
- i_fifo_data  in  DATA_WIDTH  FIFO read data, valid RD_LATENCY cycles after deq
- o_fifo_deq  out  1  FIFO read request
- o_valid  out  1  downstream data valid
- o_data  out  DATA_WIDTH  downstream data (signed)
- i_ready  in  1  downstream accept
- o_xfer_count  out  32  transfers completed (only with LI_DRAIN_STATS_EN)
- o_stall_count  out  32  cycles with o_valid && !i_ready (only with LI_DRAIN_STATS_EN)

Behaviour:
- Reset (synchronous, active-high): o_fifo_deq=0, o_valid=0, o_data=0, in-flight shift register cleared, buffer pointers/count=0. Reads in flight at reset are discarded; the FIFO shares the same reset.
- In-flight tracker: RD_LATENCY-bit shift register; bit0 = o_fifo_deq, and the top bit marks i_fifo_data valid this cycle.
- inflight = popcount of the shift register. occ = buffer count (0..BUF_DEPTH).
- Credit rule: o_fifo_deq = !i_fifo_empty && (occ + inflight - pop) < BUF_DEPTH, where pop = o_valid && i_ready. The term is computed combinationally in the same cycle.
- Buffer never overflows; an assertion checks that push with occ==BUF_DEPTH && !pop never occurs.
- Push: when the shift-register top bit is 1, write i_fifo_data at wr_ptr. Pointers wrap modulo BUF_DEPTH.
- Pop: o_valid = (occ != 0). o_data = entry at rd_ptr (registered buffer, no combinational path from i_fifo_data). A transfer occurs when o_valid && i_ready.
- Simultaneous push and pop: occ unchanged, both pointers advance. Push into an empty buffer: o_valid rises the following cycle.
- Latency, empty pipeline, downstream ready: FIFO non-empty at cycle t -> deq at t -> o_valid at t+RD_LATENCY+1.
- i_ready low: deq continues until occ+inflight == BUF_DEPTH, then stalls. No data is lost or duplicated.
- o_data holds stable while o_valid && !i_ready.
- i_fifo_empty changing while reads are in flight has no effect on those reads.
- Width rule: occ and inflight counters are $clog2(BUF_DEPTH+1) bits; the sum is compared at one extra bit.

Optional Feature:
- LI_DRAIN_STATS_EN defined: 32-bit saturating counters o_xfer_count (+1 per transfer) and o_stall_count (+1 per cycle with o_valid && !i_ready). Both reset to 0 and hold at 32'hFFFF_FFFF.
- Undefined: both ports and counters are absent from the module entirely.

Decomposition:
- Shared package li_shell_pkg: constants LI_DEFAULT_RD_LATENCY=2 and LI_DEFAULT_BUF_DEPTH=4, plus a function li_min_buf_depth(rd_latency) that returns rd_latency+1.
- One sub-module: li_reg_buf, a parameterised register FIFO with push/pop, count, full/empty, and registered head output.
- li_fifo_drain owns the credit logic, the in-flight tracker, and the stats counters.

Test Plan:
- Reset mid-stream: FIFO holds 5 words, reset asserted for 1 cycle while 2 reads are in flight -> all outputs 0 the next cycle, and no stale word appears after reset.
- Streaming: FIFO preloaded 1..16, i_ready=1 -> o_data 1..16 on 16 consecutive o_valid cycles; first valid 3 cycles after the first deq (RD_LATENCY=2).
- Backpressure: i_ready=0 with FIFO holding 10 words -> exactly 4 deq pulses, o_valid=1 with o_data=1 held stable. Release i_ready -> words 1..10 delivered in order with no gaps after the pipeline refills.
- Bubble: FIFO empty for cycles 5-8 mid-stream -> o_valid drops after the buffer drains, resumes in order, with no duplicate or lost words.
- Random stress: random i_ready (50%), random enqueue into FIFO, 10k words -> scoreboard matches, and the overflow assertion never fires.
- Stats (macro on): 100 transfers with 37 stalled cycles -> o_xfer_count=100, o_stall_count=37.

Source files
------------

// File: rtl/li_shell_pkg.sv
// Shared constants and types for the shell's FIFO-side pipeline blocks.
// Holds default read latency/buffer depth and the minimum full-rate buffer depth.
package li_shell_pkg;

  localparam int LI_DEFAULT_RD_LATENCY = 2;
  localparam int LI_DEFAULT_BUF_DEPTH  = 4;

  localparam logic [31:0] LI_STAT_MAX = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [31:0] xfer_count;
    logic [31:0] stall_count;
  } li_drain_stats_t;

  // Smallest buffer that hides the read latency and still sustains one word per cycle.
  function automatic int li_min_buf_depth(input int rd_latency);
    return rd_latency + 1;
  endfunction

endpackage

// File: rtl/li_fifo_drain_if.sv
// FIFO-side and stream-side signals of li_fifo_drain, named from the drain's viewpoint.
// slave = the drain itself, master = whatever surrounds it (FIFO wrapper + next stage).
interface li_fifo_drain_if #(
  parameter int DATA_WIDTH = 32
);

  logic                         i_fifo_empty;
  logic [DATA_WIDTH-1:0]        i_fifo_data;
  logic                         o_fifo_deq;
  logic                         o_valid;
  logic signed [DATA_WIDTH-1:0] o_data;
  logic                         i_ready;

  modport slave (
    input  i_fifo_empty,
    input  i_fifo_data,
    input  i_ready,
    output o_fifo_deq,
    output o_valid,
    output o_data
  );

  modport master (
    output i_fifo_empty,
    output i_fifo_data,
    output i_ready,
    input  o_fifo_deq,
    input  o_valid,
    input  o_data
  );

endinterface

// File: rtl/li_reg_buf.sv
// Small register FIFO with a registered head word; DEPTH must be a power of two.
// head reads as zero whenever the buffer is empty.
module li_reg_buf
  import li_shell_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = LI_DEFAULT_BUF_DEPTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        push_data,
  input  logic                         pop,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic [DATA_WIDTH-1:0]        head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      rd_ptr_next;
  logic [CNT_W-1:0]      count_next;
  logic [DATA_WIDTH-1:0] head_next;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    rd_ptr_next = rd_ptr;
    count_next  = count;
    head_next   = '0;

    if (do_pop) rd_ptr_next = rd_ptr + 1'b1;

    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase

    // The word being written this cycle becomes head when it lands in the next read slot.
    if (count_next == '0)                       head_next = '0;
    else if (do_push && (rd_ptr_next == wr_ptr)) head_next = push_data;
    else                                         head_next = mem[rd_ptr_next];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
      head   <= head_next;
    end
  end

  // NOTE: the storage array is deliberately not reset; count and the head register decide what is visible.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/li_fifo_drain.sv
// Turns a non-showahead fixed-latency FIFO read port into a valid/ready stream using read credits.
// Optional statistics counters are built only when LI_DRAIN_STATS_EN is defined.
module li_fifo_drain
  import li_shell_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = LI_DEFAULT_RD_LATENCY,
  parameter int BUF_DEPTH  = LI_DEFAULT_BUF_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  li_fifo_drain_if.slave    bus
`ifdef LI_DRAIN_STATS_EN
  ,
  output logic [31:0]       o_xfer_count,
  output logic [31:0]       o_stall_count
`endif
);

  localparam int CNT_W     = $clog2(BUF_DEPTH + 1);
  localparam int SUM_W     = CNT_W + 1;
  localparam int MIN_DEPTH = li_min_buf_depth(RD_LATENCY);

  logic [RD_LATENCY-1:0] rd_track;
  logic [CNT_W-1:0]      occ;
  logic [CNT_W-1:0]      inflight;
  logic [SUM_W-1:0]      credit_sum;
  logic                  land;
  logic                  pop;
  logic                  deq;
  logic                  buf_full;
  logic                  buf_empty;
  logic [DATA_WIDTH-1:0] head;

  assign land = rd_track[RD_LATENCY-1];
  assign pop  = bus.o_valid && bus.i_ready;

  // NOTE: every always_comb output is given a default before any branch so no latch is inferred.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CNT_W'(rd_track[i]);
  end

  // Words already buffered plus words still on their way must leave room for one more.
  assign credit_sum = {1'b0, occ} + {1'b0, inflight} - SUM_W'(pop);
  assign deq        = !reset && !bus.i_fifo_empty && (credit_sum < SUM_W'(BUF_DEPTH));

  assign bus.o_fifo_deq = deq;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_track <= '0;
    end else begin
      rd_track[0] <= deq;
      for (int i = 1; i < RD_LATENCY; i++) rd_track[i] <= rd_track[i-1];
    end
  end

  li_reg_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_buf (
    .clock     (clock),
    .reset     (reset),
    .push      (land),
    .push_data (bus.i_fifo_data),
    .pop       (pop),
    .count     (occ),
    .full      (buf_full),
    .empty     (buf_empty),
    .head      (head)
  );

  assign bus.o_valid = !buf_empty;
  assign bus.o_data  = head;

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(land && buf_full && !pop));

  a_depth_cfg: assert property (@(posedge clock)
    (BUF_DEPTH >= MIN_DEPTH) && (RD_LATENCY >= 1) && (RD_LATENCY <= 4));

`ifdef LI_DRAIN_STATS_EN
  li_drain_stats_t stats;

  always_ff @(posedge clock) begin
    if (reset) begin
      stats <= '0;
    end else begin
      if (pop && (stats.xfer_count != LI_STAT_MAX))
        stats.xfer_count <= stats.xfer_count + 32'd1;
      if (bus.o_valid && !bus.i_ready && (stats.stall_count != LI_STAT_MAX))
        stats.stall_count <= stats.stall_count + 32'd1;
    end
  end

  assign o_xfer_count  = stats.xfer_count;
  assign o_stall_count = stats.stall_count;
`endif

endmodule

// File: tb/tb_li_fifo_drain.sv
// Directed and randomised bench for li_fifo_drain with a behavioural fixed-latency FIFO model.
// Statistics checks are included when LI_DRAIN_STATS_EN is defined.
module tb_li_fifo_drain;

  localparam int          DW     = 32;
  localparam int          RD_LAT = 2;
  localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;

  logic clock = 1'b0;
  logic reset;

  li_fifo_drain_if #(.DATA_WIDTH(DW)) bus ();

`ifdef LI_DRAIN_STATS_EN
  logic [31:0] xfer_count;
  logic [31:0] stall_count;
`endif

  li_fifo_drain #(
    .DATA_WIDTH (DW),
    .RD_LATENCY (RD_LAT),
    .BUF_DEPTH  (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus)
`ifdef LI_DRAIN_STATS_EN
    ,
    .o_xfer_count  (xfer_count),
    .o_stall_count (stall_count)
`endif
  );

  initial forever #5 clock = ~clock;

  int checks = 0;
  int passed = 0;
  int deq_pulses = 0;

  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] rd_pipe [RD_LAT];

  task automatic fifo_push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    bus.i_fifo_empty = 1'b0;
  endtask

  // One clock cycle: sample the request before the edge, advance the FIFO model after it.
  task automatic step();
    logic          deq_s;
    logic          rst_s;
    logic [DW-1:0] w;
    #1;
    deq_s = bus.o_fifo_deq;
    rst_s = reset;
    w     = JUNK;
    if (!rst_s && deq_s) begin
      deq_pulses++;
      if (fifo_q.size() == 0) begin
        checks++;
        $display("FAIL deq_on_empty: deq=1 while model FIFO holds 0 words");
      end else begin
        w = fifo_q.pop_front();
      end
    end
    @(posedge clock);
    #1;
    if (rst_s) begin
      fifo_q.delete();
      for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = JUNK;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
      rd_pipe[0] = w;
    end
    bus.i_fifo_data  = rd_pipe[RD_LAT-1];
    bus.i_fifo_empty = (fifo_q.size() == 0);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bus.i_ready = 1'b0;
    step();
    reset       = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (bus.o_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", bus.o_valid);
    else passed++;
    checks++;
    if (bus.o_data !== 32'sd0) $display("FAIL reset_data: got %0h want 0", bus.o_data);
    else passed++;
    checks++;
    if (bus.o_fifo_deq !== 1'b0) $display("FAIL reset_deq: got %0b want 0", bus.o_fifo_deq);
    else passed++;
  endtask

  task automatic test_reset_midstream();
    int d0;
    int stale;
    do_reset();
    bus.i_ready = 1'b1;
    for (int i = 0; i < 5; i++) fifo_push(32'(100 + i));
    d0 = deq_pulses;
    step();
    step();
    checks++;
    if (deq_pulses - d0 !== 2) $display("FAIL midreset_inflight: got %0d deq want 2", deq_pulses - d0);
    else passed++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_data !== 32'sd0 || bus.o_fifo_deq !== 1'b0)
      $display("FAIL midreset_outputs: got valid=%0b data=%0h deq=%0b want 0/0/0",
               bus.o_valid, bus.o_data, bus.o_fifo_deq);
    else passed++;
    stale = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (bus.o_valid === 1'b1) stale++;
    end
    checks++;
    if (stale !== 0) $display("FAIL midreset_stale: got %0d valid cycles want 0", stale);
    else passed++;
  endtask

  task automatic test_streaming();
    int first_deq;
    int first_val;
    int last_val;
    int got;
    int gaps;
    do_reset();
    bus.i_ready = 1'b1;
    for (int i = 1; i <= 16; i++) fifo_push(32'(i));
    #1;
    first_deq = -1; first_val = -1; last_val = -1; got = 0; gaps = 0;
    for (int c = 0; c < 60 && got < 16; c++) begin
      if (bus.o_fifo_deq === 1'b1 && first_deq < 0) first_deq = c;
      if (bus.o_valid === 1'b1) begin
        if (first_val < 0) first_val = c;
        else if (last_val != c - 1) gaps++;
        checks++;
        if (bus.o_data !== 32'(got + 1))
          $display("FAIL stream_data: got %0d want %0d", bus.o_data, got + 1);
        else passed++;
        got++;
        last_val = c;
      end
      step();
    end
    checks++;
    if (got !== 16) $display("FAIL stream_count: got %0d words want 16", got);
    else passed++;
    checks++;
    if (first_val - first_deq !== 3)
      $display("FAIL stream_latency: got %0d cycles want 3", first_val - first_deq);
    else passed++;
    checks++;
    if (gaps !== 0) $display("FAIL stream_gaps: got %0d gaps want 0", gaps);
    else passed++;
  endtask

  task automatic test_backpressure();
    int d0;
    int hold_err;
    int got;
    int last_val;
    int gaps;
    do_reset();
    bus.i_ready = 1'b0;
    for (int i = 1; i <= 10; i++) fifo_push(32'(i));
    d0 = deq_pulses;
    hold_err = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus.o_valid === 1'b1 && bus.o_data !== 32'sd1) hold_err++;
    end
    checks++;
    if (deq_pulses - d0 !== 4) $display("FAIL bp_deq_count: got %0d want 4", deq_pulses - d0);
    else passed++;
    checks++;
    if (bus.o_valid !== 1'b1) $display("FAIL bp_valid: got %0b want 1", bus.o_valid);
    else passed++;
    checks++;
    if (bus.o_data !== 32'sd1) $display("FAIL bp_data: got %0d want 1", bus.o_data);
    else passed++;
    checks++;
    if (hold_err !== 0) $display("FAIL bp_hold: got %0d unstable cycles want 0", hold_err);
    else passed++;

    bus.i_ready = 1'b1;
    got = 0; last_val = -1; gaps = 0;
    for (int c = 0; c < 40 && got < 10; c++) begin
      if (bus.o_valid === 1'b1) begin
        if (last_val >= 0 && last_val != c - 1) gaps++;
        checks++;
        if (bus.o_data !== 32'(got + 1))
          $display("FAIL bp_release_data: got %0d want %0d", bus.o_data, got + 1);
        else passed++;
        got++;
        last_val = c;
      end
      step();
    end
    checks++;
    if (got !== 10) $display("FAIL bp_release_count: got %0d want 10", got);
    else passed++;
    checks++;
    if (gaps !== 0) $display("FAIL bp_release_gaps: got %0d want 0", gaps);
    else passed++;
  endtask

  task automatic test_bubble();
    int next_in;
    int got;
    bit saw_drop;
    do_reset();
    bus.i_ready = 1'b1;
    next_in = 1; got = 0; saw_drop = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c < 5 || (c >= 9 && c < 14)) begin
        fifo_push(32'(next_in));
        next_in++;
      end
      if (bus.o_valid === 1'b1) begin
        checks++;
        if (bus.o_data !== 32'(got + 1))
          $display("FAIL bubble_data: got %0d want %0d", bus.o_data, got + 1);
        else passed++;
        got++;
      end else if (got > 0 && got < 10) begin
        saw_drop = 1'b1;
      end
      step();
    end
    checks++;
    if (got !== 10) $display("FAIL bubble_count: got %0d words want 10", got);
    else passed++;
    checks++;
    if (saw_drop !== 1'b1) $display("FAIL bubble_drop: got %0b want 1", saw_drop);
    else passed++;
  endtask

  task automatic test_random();
    logic [DW-1:0] sb [$];
    logic [DW-1:0] w;
    logic [DW-1:0] exp_w;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    int sent;
    int got;
    do_reset();
    sent = 0; got = 0; prev_stall = 1'b0; prev_data = '0;
    for (int c = 0; c < 60000 && got < 10000; c++) begin
      if (sent < 10000 && $urandom_range(0, 99) < 60) begin
        w = $urandom();
        fifo_push(w);
        sb.push_back(w);
        sent++;
      end
      bus.i_ready = 1'($urandom_range(0, 1));
      if (prev_stall) begin
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== prev_data)
          $display("FAIL rand_hold: got valid=%0b data=%0h want 1/%0h",
                   bus.o_valid, bus.o_data, prev_data);
        else passed++;
      end
      if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
        exp_w = (sb.size() != 0) ? sb.pop_front() : JUNK;
        checks++;
        if (bus.o_data !== exp_w)
          $display("FAIL rand_data: word %0d got %0h want %0h", got, bus.o_data, exp_w);
        else passed++;
        got++;
      end
      prev_stall = (bus.o_valid === 1'b1) && (bus.i_ready === 1'b0);
      prev_data  = bus.o_data;
      step();
    end
    checks++;
    if (got !== 10000) $display("FAIL rand_count: got %0d words want 10000", got);
    else passed++;
  endtask

`ifdef LI_DRAIN_STATS_EN
  task automatic test_stats();
    int got;
    int stalls;
    do_reset();
    checks++;
    if (xfer_count !== 32'd0 || stall_count !== 32'd0)
      $display("FAIL stats_reset: got %0d/%0d want 0/0", xfer_count, stall_count);
    else passed++;
    for (int i = 0; i < 100; i++) fifo_push(32'(i));
    got = 0; stalls = 0;
    for (int c = 0; c < 1000 && got < 100; c++) begin
      if (bus.o_valid === 1'b1 && stalls < 37 && (c % 2 == 0)) begin
        bus.i_ready = 1'b0;
        stalls++;
      end else begin
        bus.i_ready = 1'b1;
      end
      if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) got++;
      step();
    end
    bus.i_ready = 1'b0;
    checks++;
    if (xfer_count !== 32'd100) $display("FAIL stats_xfer: got %0d want 100", xfer_count);
    else passed++;
    checks++;
    if (stall_count !== 32'd37) $display("FAIL stats_stall: got %0d want 37", stall_count);
    else passed++;
  endtask
`endif

  initial begin
    reset            = 1'b1;
    bus.i_ready      = 1'b0;
    bus.i_fifo_empty = 1'b1;
    bus.i_fifo_data  = JUNK;
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = JUNK;

    test_reset();
    test_reset_midstream();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_random();
`ifdef LI_DRAIN_STATS_EN
    test_stats();
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
